// File: rtl/song_sequencer_if.sv
// song_sequencer_if: run control, order-list ROM port and pattern/note outputs of the song sequencer
interface song_sequencer_if;
  logic       i_enable;
  logic       i_restart;
  logic [3:0] o_order_addr;
  logic [9:0] i_order_data;
  logic [4:0] o_new_addr;
  logic [4:0] o_new_pattern_len;
  logic       o_new_addr_valid;
  logic       o_note_stb;
  logic [3:0] o_song_pos;
  logic       o_busy;
  modport master (
    input  i_enable, i_restart, i_order_data,
    output o_order_addr, o_new_addr, o_new_pattern_len, o_new_addr_valid, o_note_stb, o_song_pos, o_busy
  );
  modport slave (
    output i_enable, i_restart, i_order_data,
    input  o_order_addr, o_new_addr, o_new_pattern_len, o_new_addr_valid, o_note_stb, o_song_pos, o_busy
  );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: walks the order list, hands each pattern to the note sequencer and emits note ticks
module song_sequencer #(
  parameter logic [15:0] TICK_DIV  = 16'd1000,
  parameter int          ORDER_LEN = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  song_sequencer_if.master  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] PLAY  = 2'd3;
  logic [1:0]  state;
  logic [3:0]  idx;
  logic [3:0]  nxt_idx;
  logic [15:0] div;
  logic [4:0]  rem;
  logic [4:0]  addr_q;
  logic [4:0]  len_q;
  logic [4:0]  len;
  logic        load_ok;
  logic        tick;
  assign len     = bus.i_order_data[9:5];
  assign nxt_idx = idx == 4'(ORDER_LEN - 1) ? 4'd0 : idx + 4'd1;
  // ROM data arrives during LOAD, so the pattern hand-off is presented combinationally in that cycle
  assign load_ok = state == LOAD && len != 5'd0 && !bus.i_restart && !i_rst;
  assign tick    = state == PLAY && bus.i_enable && div == TICK_DIV - 16'd1 && !bus.i_restart && !i_rst;
  assign bus.o_order_addr      = idx;
  assign bus.o_song_pos        = idx;
  assign bus.o_busy            = state != IDLE;
  assign bus.o_new_addr_valid  = load_ok;
  assign bus.o_note_stb        = tick;
  assign bus.o_new_addr        = load_ok ? bus.i_order_data[4:0] : addr_q;
  assign bus.o_new_pattern_len = load_ok ? len : len_q;
  // sequencing FSM: restart overrides everything but reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      idx    <= 4'd0;
      div    <= 16'd0;
      rem    <= 5'd0;
      addr_q <= 5'd0;
      len_q  <= 5'd0;
    end else if (bus.i_restart) begin
      state <= bus.i_enable ? FETCH : IDLE;
      idx   <= 4'd0;
      div   <= 16'd0;
      rem   <= 5'd0;
    end else begin
      case (state)
        IDLE:  state <= bus.i_enable ? FETCH : IDLE;
        FETCH: state <= LOAD;
        LOAD: begin
          if (len != 5'd0) begin
            addr_q <= bus.i_order_data[4:0];
            len_q  <= len;
            rem    <= len;
            div    <= 16'd0;
            state  <= PLAY;
          end else begin
            idx   <= nxt_idx;
            state <= FETCH;
          end
        end
        PLAY: begin
          if (tick) begin
            div <= 16'd0;
            rem <= rem - 5'd1;
            if (rem == 5'd1) begin
              idx   <= nxt_idx;
              state <= FETCH;
            end
          end else if (bus.i_enable) begin
            div <= div + 16'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed timing scenarios plus randomized run/pause/restart/reset against a reference model
module tb_song_sequencer;
  localparam int TD = 4;
  localparam int OL = 3;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] rom [16];
  logic [9:0] rom_q;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t = 0;
  bit en_v, rs_v, rst_v;
  int vq[$], sq[$], xv[$], xs[$];
  int m_mode, m_pos, m_load_at, m_en_cnt, m_len, m_ea, m_el;
  song_sequencer_if bus ();
  song_sequencer #(.TICK_DIV(16'(TD)), .ORDER_LEN(OL)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // registered order-list ROM: data valid one cycle after the address
  always @(posedge clk) rom_q <= rom[bus.o_order_addr];
  assign bus.i_order_data = rom_q;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    int l, p_old;
    bit ev, es, b_old;
    @(negedge clk);
    rst = rst_v;
    bus.i_enable = en_v;
    bus.i_restart = rs_v;
    #1;
    ev = 0;
    es = 0;
    p_old = m_pos;
    b_old = m_mode != 0;
    if (rst_v) begin
      check("rst_valid", int'(bus.o_new_addr_valid), 0);
      check("rst_stb", int'(bus.o_note_stb), 0);
      m_mode = 0; m_pos = 0; m_ea = 0; m_el = 0;
    end else begin
      if (rs_v) begin
        m_pos = 0;
        m_mode = en_v ? 1 : 0;
        m_load_at = t + 2;
      end else if (m_mode == 0) begin
        if (en_v) begin
          m_mode = 1;
          m_load_at = t + 2;
        end
      end else if (m_mode == 1) begin
        if (t == m_load_at) begin
          l = int'(rom[p_old]) >> 5;
          if (l != 0) begin
            ev = 1;
            m_ea = int'(rom[p_old]) & 31;
            m_el = l;
            m_len = l;
            m_en_cnt = 0;
            m_mode = 2;
          end else begin
            m_pos = (p_old + 1) % OL;
            m_load_at = t + 2;
          end
        end
      end else if (en_v) begin
        m_en_cnt++;
        es = (m_en_cnt % TD) == 0;
        if (m_en_cnt == m_len * TD) begin
          m_pos = (p_old + 1) % OL;
          m_mode = 1;
          m_load_at = t + 2;
        end
      end
      check("valid", int'(bus.o_new_addr_valid), int'(ev));
      check("note_stb", int'(bus.o_note_stb), int'(es));
      check("new_addr", int'(bus.o_new_addr), m_ea);
      check("new_len", int'(bus.o_new_pattern_len), m_el);
      check("song_pos", int'(bus.o_song_pos), p_old);
      check("order_addr", int'(bus.o_order_addr), p_old);
      check("busy", int'(bus.o_busy), int'(b_old));
    end
    if (bus.o_new_addr_valid) vq.push_back(cyc);
    if (bus.o_note_stb) sq.push_back(cyc);
    cyc++;
    t++;
  endtask
  task automatic scen(input int n, input int en_at, input int p0, input int p1, input int rs_at);
    vq.delete();
    sq.delete();
    rst_v = 1; en_v = 0; rs_v = 0;
    step();
    step();
    rst_v = 0;
    cyc = 0;
    for (int c = 0; c < n; c++) begin
      en_v = c >= en_at && !(c >= p0 && c < p1);
      rs_v = c == rs_at;
      step();
    end
  endtask
  task automatic cmp_events(input string tag);
    check({tag, "_nvalid"}, vq.size(), xv.size());
    check({tag, "_nstb"}, sq.size(), xs.size());
    foreach (xv[i]) if (i < vq.size()) check({tag, "_valid_cyc"}, vq[i], xv[i]);
    foreach (xs[i]) if (i < sq.size()) check({tag, "_stb_cyc"}, sq[i], xs[i]);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 10'd0;
    rst = 1'b1;
    bus.i_enable = 1'b0;
    bus.i_restart = 1'b0;
    m_mode = 0; m_pos = 0; m_load_at = 0; m_en_cnt = 0; m_len = 0; m_ea = 0; m_el = 0;
    rom[0] = {5'd3, 5'd5};
    rom[1] = {5'd1, 5'd0};
    rom[2] = {5'd2, 5'd9};
    scen(43, 10, 999, 999, -1);
    xv = '{12, 26, 32, 42};
    xs = '{16, 20, 24, 30, 36, 40};
    cmp_events("basic");
    scen(20, 10, 999, 999, -1);
    scen(43, 10, 999, 999, -1);
    cmp_events("after_rst");
    scen(37, 10, 17, 27, -1);
    xv = '{12, 36};
    xs = '{16, 30, 34};
    cmp_events("pause");
    scen(40, 10, 999, 999, 35);
    xv = '{12, 26, 32, 37};
    xs = '{16, 20, 24, 30};
    cmp_events("restart");
    rom[1] = {5'd0, 5'd7};
    scen(39, 10, 999, 999, -1);
    xv = '{12, 28, 38};
    xs = '{16, 20, 24, 32, 36};
    cmp_events("skip");
    rom[0] = 10'd3; rom[1] = 10'd9; rom[2] = 10'd31;
    scen(110, 10, 999, 999, -1);
    xv = {};
    xs = {};
    cmp_events("all_zero");
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < OL; i++) rom[i] = {($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 3)), 5'($urandom)};
      rst_v = 1; en_v = 0; rs_v = 0;
      step();
      rst_v = 0;
      for (int c = 0; c < 300; c++) begin
        en_v = $urandom_range(0, 9) != 0;
        rs_v = $urandom_range(0, 49) == 0;
        rst_v = $urandom_range(0, 199) == 0;
        step();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 16'd1000, meaning clocks per note tick; legal range 2..65535.
REQ-002 SHALL have parameter ORDER_LEN, default 8, meaning number of order-list entries; legal range 1..16.
REQ-003 SHALL have port i_clk  input  1  meaning single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_enable  input  1  meaning run (1) or pause (0).
REQ-006 SHALL have port i_restart  input  1  meaning single-cycle pulse that restarts the song at order entry 0.
REQ-007 SHALL have port o_order_addr  output  4  meaning address into the order-list ROM.
REQ-008 SHALL have port i_order_data  input  10  meaning ROM data {len[9:5], pattern_addr[4:0]}, valid exactly 1 cycle after o_order_addr.
REQ-009 SHALL have port o_new_addr  output  5  meaning pattern start address for the note sequencer.
REQ-010 SHALL have port o_new_pattern_len  output  5  meaning pattern length in notes.
REQ-011 SHALL have port o_new_addr_valid  output  1  meaning 1-cycle qualifier for o_new_addr and o_new_pattern_len.
REQ-012 SHALL have port o_note_stb  output  1  meaning 1-cycle note-tick strobe.
REQ-013 SHALL have port o_song_pos  output  4  meaning current order index.
REQ-014 SHALL have port o_busy  output  1  meaning 1 whenever state != IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, FETCH, LOAD and PLAY.
REQ-016 SHALL drive o_order_addr = o_song_pos in every state.
REQ-017 SHALL, in IDLE, move to FETCH on the first cycle i_enable=1 and otherwise stay in IDLE.
REQ-018 SHALL always pass from FETCH to LOAD after one cycle, independent of i_enable.
REQ-019 SHALL, in LOAD with len!=0: register pattern_addr to o_new_addr and len to o_new_pattern_len, assert o_new_addr_valid for that cycle only, set remaining=len, clear the tick divider to 0, and go to PLAY.
REQ-020 SHALL, in LOAD with len==0: not assert o_new_addr_valid, skip the entry (advance index), and go to FETCH.
REQ-021 SHALL, in PLAY with i_enable=1, increment the divider each cycle.
REQ-022 SHALL, when divider==TICK_DIV-1, assert o_note_stb for that cycle, wrap the divider to 0 and decrement remaining.
REQ-023 SHALL, on a strobe with remaining==1, advance the index and go to FETCH in the same cycle.
REQ-024 SHALL, in PLAY with i_enable=0, hold the divider, remaining and state, with no strobe.
REQ-025 SHALL advance the index as index==ORDER_LEN-1 -> 0, else index+1 (wrap).
REQ-026 SHALL, when ORDER_LEN=1, reload entry 0 after every pattern.
REQ-027 SHALL, when all ORDER_LEN entries have len==0, cycle FETCH/LOAD indefinitely with no valid or strobe; this is legal and must not lock up or overflow.
REQ-028 SHALL, on i_restart (any state): set index=0, divider=0, remaining=0, and go to FETCH if i_enable=1, else IDLE; no strobe or valid that cycle.
REQ-029 SHALL give i_restart priority over all FSM activity; i_rst has priority over i_restart.
REQ-030 SHALL have the timing: i_enable rises in IDLE at cycle N -> FETCH N+1, LOAD/valid N+2, first o_note_stb N+2+TICK_DIV.
REQ-031 SHALL produce, for a pattern of length L, exactly L strobes spaced TICK_DIV cycles apart (absent pause), with next valid 2 cycles after the last strobe.
REQ-032 SHALL hold o_new_addr and o_new_pattern_len stable between valid pulses.
REQ-033 SHALL never assert o_note_stb and o_new_addr_valid in the same cycle.

Reset
REQ-034 SHALL, on i_rst, set: state=IDLE, index=0, divider=0, remaining=0.
REQ-035 SHALL, on i_rst, drive outputs to: o_order_addr=0, o_new_addr=0, o_new_pattern_len=0, o_new_addr_valid=0, o_note_stb=0, o_song_pos=0, o_busy=0.
REQ-036 SHALL let reset mid-PLAY abort immediately with no further strobes until re-enabled.

Verification
REQ-037 SHALL cover, with TICK_DIV=4, ORDER_LEN=3, ROM={len3/addr5, len1/addr0, len2/addr9}: enable at cycle 10 -> valid(5,3) at 12, strobes at 16,20,24; valid(0,1) at 26, strobe 30; valid(9,2) at 32, strobes 36,40; valid(5,3) at 42 (wrap).
REQ-038 SHALL cover entry 1 set to len0: after the entry-0 strobes (24), no valid at 26; valid(9,2) at 28.
REQ-039 SHALL cover pause: i_enable=0 for 10 cycles starting after strobe 16 -> next strobe at 30, remaining intact, pattern still ends after 3 strobes.
REQ-040 SHALL cover i_restart during entry 2 with i_enable=1 -> FETCH next cycle, o_song_pos=0, valid(5,3) 2 cycles after restart.
REQ-041 SHALL cover i_rst asserted mid-PLAY -> all outputs 0, o_busy=0, IDLE; re-enable reproduces the REQ-037 timing.
REQ-042 SHALL cover an all-zero-length ROM -> o_busy=1, no valid or strobe for 100 cycles, o_song_pos cycling 0,1,2.
